// File: rtl/rtl_subtractor_pkg.sv
// Shared types and constants for the digit-serial subtractor.
package rtl_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_DIGIT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int unsigned num_digits(input int unsigned width,
                                               input int unsigned digit_w);
        return width / digit_w;
    endfunction

endpackage

// File: rtl/rtl_sub_digit.sv
// One DIGIT_W-bit subtract slice: d = x - y - bin, bout = borrow out.
module rtl_sub_digit #(
    parameter int unsigned DIGIT_W = 8
) (
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bin,
    output logic [DIGIT_W-1:0] d,
    output logic               bout
);

    // The extra top bit of the widened difference is exactly the borrow.
    assign {bout, d} = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bin};

endmodule

// File: rtl/rtl_subtractor_serial.sv
// Digit-serial subtractor with valid/ready handshakes; one digit per RUN cycle.
// Define RTL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module rtl_subtractor_serial
    import rtl_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned DIGIT_W = DEFAULT_DIGIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef RTL_SUBTRACTOR_OVF_EN
    output logic             ovf,
`endif
    output logic             bo
);

    localparam int unsigned N     = num_digits(WIDTH, DIGIT_W);
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if ((WIDTH % DIGIT_W) != 0 || DIGIT_W == 0) begin : g_width_check
        $error("WIDTH must be a nonzero multiple of DIGIT_W");
    end

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               borrow;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT_W-1:0] x;
    logic [DIGIT_W-1:0] y;
    logic [DIGIT_W-1:0] d;
    logic               bout;

    assign x = a_q[cnt*DIGIT_W +: DIGIT_W];
    assign y = b_q[cnt*DIGIT_W +: DIGIT_W];

    rtl_sub_digit #(
        .DIGIT_W(DIGIT_W)
    ) u_digit (
        .x   (x),
        .y   (y),
        .bin (borrow),
        .d   (d),
        .bout(bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            borrow    <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            bo        <= 1'b0;
`ifdef RTL_SUBTRACTOR_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow   <= 1'b0;
                        cnt      <= '0;
                        diff     <= '0;
                        bo       <= 1'b0;
`ifdef RTL_SUBTRACTOR_OVF_EN
                        ovf      <= 1'b0;
`endif
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff[cnt*DIGIT_W +: DIGIT_W] <= d;
                    borrow <= bout;
                    if (cnt == LAST) begin
                        bo        <= bout;
`ifdef RTL_SUBTRACTOR_OVF_EN
                        // d's MSB is the final diff MSB on the last digit.
                        ovf       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                     (d[DIGIT_W-1] != a_q[WIDTH-1]);
`endif
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtl_subtractor_serial.sv
// Self-checking bench for rtl_subtractor_serial against an arithmetic reference model.
module tb_rtl_subtractor_serial;

    localparam int WIDTH   = 32;
    localparam int DIGIT_W = 8;
    localparam int N       = WIDTH / DIGIT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bo;
`ifdef RTL_SUBTRACTOR_OVF_EN
    logic             ovf;
`endif

    int tests = 0;
    int fails = 0;

    rtl_subtractor_serial #(
        .WIDTH  (WIDTH),
        .DIGIT_W(DIGIT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
`ifdef RTL_SUBTRACTOR_OVF_EN
        .ovf      (ovf),
`endif
        .bo       (bo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: modular difference, unsigned compare, signed range check.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] ed, output logic eb, output logic eo);
        longint s;
        ed = ma - mb;
        eb = (ma < mb);
        s  = longint'($signed(ma)) - longint'($signed(mb));
        eo = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endtask

    task automatic check_result(input string name, input logic [31:0] ed,
                                input logic eb, input logic eo);
        tests++;
        if (diff !== ed) begin
            fails++;
            $display("FAIL %s diff: got %h expected %h", name, diff, ed);
        end
        tests++;
        if (bo !== eb) begin
            fails++;
            $display("FAIL %s bo: got %b expected %b", name, bo, eb);
        end
`ifdef RTL_SUBTRACTOR_OVF_EN
        tests++;
        if (ovf !== eo) begin
            fails++;
            $display("FAIL %s ovf: got %b expected %b", name, ovf, eo);
        end
`else
        if (eo === 1'bx) $display("model ovf undefined for %s", name);
`endif
    endtask

    // Full transaction: accept, check latency and result, then drain.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input string name);
        int          lat;
        logic [31:0] ed;
        logic        eb;
        logic        eo;
        model(ta, tb_, ed, eb, eo);
        lat = 0;
        while (!in_ready && lat < 20) begin
            tick();
            lat++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s in_ready timeout: got %b expected 1", name, in_ready);
        end
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        tests++;
        if (lat !== N) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, N);
        end
        check_result(name, ed, eb, eo);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s drain: got out_valid=%b in_ready=%b expected 0/1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 || bo !== 1'b0) begin
            fails++;
            $display("FAIL reset: got in_ready=%b out_valid=%b diff=%h bo=%b expected 1/0/0/0",
                     in_ready, out_valid, diff, bo);
        end
`ifdef RTL_SUBTRACTOR_OVF_EN
        tests++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset ovf: got %b expected 0", ovf);
        end
`endif
    endtask

    task automatic test_directed();
        run_op(32'd5, 32'd3, "5-3");
        run_op(32'd3, 32'd5, "3-5");
        run_op(32'h8000_0000, 32'd1, "min-1");
        run_op(32'h0000_0100, 32'd1, "digit_borrow");
        run_op(32'h0000_0000, 32'hFFFF_FFFF, "0-max");
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, "max_pos-neg1");
        run_op(32'h1234_5678, 32'h1234_5678, "equal");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op($urandom, $urandom, "random");
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ed;
        logic [31:0] a2;
        logic [31:0] b2;
        logic        eb;
        logic        eo;
        int          lat;
        model(32'hDEAD_BEEF, 32'h0BAD_F00D, ed, eb, eo);
        a = 32'hDEAD_BEEF;
        b = 32'h0BAD_F00D;
        in_valid = 1'b1;
        tick();
        a2 = $urandom;
        b2 = $urandom;
        a = a2;
        b = b2;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== ed || bo !== eb) begin
                fails++;
                $display("FAIL backpressure hold %0d: got ov=%b ir=%b diff=%h bo=%b expected 1/0/%h/%b",
                         i, out_valid, in_ready, diff, bo, ed, eb);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL backpressure drain: got ir=%b ov=%b expected 1/0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL backpressure second accept: got in_ready=%b expected 0", in_ready);
        end
        model(a2, b2, ed, eb, eo);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        tests++;
        if (lat !== N) begin
            fails++;
            $display("FAIL backpressure second latency: got %0d expected %0d", lat, N);
        end
        check_result("backpressure_second", ed, eb, eo);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 || bo !== 1'b0) begin
            fails++;
            $display("FAIL midrun reset: got ir=%b ov=%b diff=%h bo=%b expected 1/0/0/0",
                     in_ready, out_valid, diff, bo);
        end
        tick();
        rst = 1'b0;
        run_op(32'd10, 32'd4, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
